// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - command, ALU-issue and response signal bundle for alu_seq
// slave is the sequencer side; master is the command source plus external ALU.
interface alu_seq_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [1:0]   cmd_rd;
  logic [1:0]   cmd_rs1;
  logic [1:0]   cmd_rs2;
  logic         cmd_imm_en;
  logic [W-1:0] cmd_imm;
  logic         cmd_we;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         alu_zero;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_we,
    input  alu_result, alu_carry, alu_zero,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_we,
    output alu_result, alu_carry, alu_zero,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - register-file sequencer issuing one command at a time to an external ALU
// Flow: accept in IDLE, one EXEC cycle, hold the response in RESP until consumed.
module alu_seq #(
  parameter int W    = 4,
  parameter int NREG = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic           started;
  logic [W-1:0]   regs [NREG];
  logic [AW-1:0]  rd_q;
  logic           we_q;
  logic [W-1:0]   alu_a_q;
  logic [W-1:0]   alu_b_q;
  logic [3:0]     alu_op_q;
  logic [W-1:0]   rsp_result_q;
  logic           rsp_carry_q;
  logic           rsp_zero_q;
  logic           rsp_err_q;

  logic           accept;
  logic           legal;
  logic           single_op;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b0110, 4'b1111: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

  // Single-operand ops (NOT A, PASS A) take the immediate on the A side.
  always_comb begin
    legal     = is_legal(bus.cmd_op);
    single_op = (bus.cmd_op == 4'b0100) || (bus.cmd_op == 4'b1111);
    op_a      = regs[bus.cmd_rs1];
    op_b      = regs[bus.cmd_rs2];
    if (bus.cmd_imm_en) begin
      if (single_op) begin
        op_a = bus.cmd_imm;
      end else begin
        op_b = bus.cmd_imm;
      end
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid && started) begin
          accept   = 1'b1;
          state_nx = legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        state_nx = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // started keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      rd_q         <= '0;
      we_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept && legal) begin
        alu_a_q  <= op_a;
        alu_b_q  <= op_b;
        alu_op_q <= bus.cmd_op;
        rd_q     <= bus.cmd_rd;
        we_q     <= bus.cmd_we;
      end
      if (accept && !legal) begin
        rsp_result_q <= '0;
        rsp_carry_q  <= 1'b0;
        rsp_zero_q   <= 1'b0;
        rsp_err_q    <= 1'b1;
      end
      // The only register-file write path: the EXEC->RESP edge.
      if (state == EXEC) begin
        rsp_result_q <= bus.alu_result;
        rsp_carry_q  <= bus.alu_carry;
        rsp_zero_q   <= bus.alu_zero;
        rsp_err_q    <= 1'b0;
        if (we_q) begin
          regs[rd_q] <= bus.alu_result;
        end
      end
    end
  end

  assign bus.cmd_ready  = started && (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural ALU and register model
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_if #(.W(4)) bus ();

  alu_seq #(.W(4), .NREG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: returns {carry, zero, result}.
  function automatic logic [5:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [3:0] r;
    logic       c;
    p = 8'h00;
    r = 4'h0;
    c = 1'b0;
    case (op)
      4'h0: {c, r} = {1'b0, a} + {1'b0, b};
      4'h1: begin r = a - b; c = (a < b); end
      4'h2: r = a & b;
      4'h4: r = ~a;
      4'h5: begin p = {4'h0, a} * {4'h0, b}; r = p[3:0]; c = |p[7:4]; end
      4'h6: begin
        if (b == 4'h0) begin r = 4'hF; c = 1'b1; end
        else r = a / b;
      end
      4'hF: r = a;
      default: r = 4'h0;
    endcase
    return {c, (r == 4'h0), r};
  endfunction

  logic [5:0] alu_out;
  assign alu_out        = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_result = alu_out[3:0];
  assign bus.alu_zero   = alu_out[4];
  assign bus.alu_carry  = alu_out[5];

  logic [3:0] model_regs [4];
  logic [3:0] last_a, last_b, last_op;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h4) ||
           (op == 4'h5) || (op == 4'h6) || (op == 4'hF);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 4'h0;
    last_a  = 4'h0;
    last_b  = 4'h0;
    last_op = 4'h0;
  endtask

  task automatic check_rsp(input string tag, input logic legal, input logic [5:0] exp);
    check({tag, "_rsp_valid"}, {7'd0, bus.rsp_valid}, 8'd1);
    check({tag, "_cmd_ready_low"}, {7'd0, bus.cmd_ready}, 8'd0);
    check({tag, "_rsp_err"}, {7'd0, bus.rsp_err}, {7'd0, !legal});
    if (legal) begin
      check({tag, "_rsp_result"}, {4'd0, bus.rsp_result}, {4'd0, exp[3:0]});
      check({tag, "_rsp_zero"}, {7'd0, bus.rsp_zero}, {7'd0, exp[4]});
      check({tag, "_rsp_carry"}, {7'd0, bus.rsp_carry}, {7'd0, exp[5]});
    end
  endtask

  // Called at a negedge with the block idle; returns at a negedge with it idle again.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic imm_en,
                         input logic [3:0] imm, input logic we, input int hold);
    logic       legal, single;
    logic [3:0] ea, eb;
    logic [5:0] exp;
    legal  = op_legal(op);
    single = (op == 4'h4) || (op == 4'hF);
    ea     = (imm_en && single) ? imm : model_regs[rs1];
    eb     = (imm_en && !single) ? imm : model_regs[rs2];
    exp    = alu_fn(op, ea, eb);

    check({tag, "_cmd_ready"}, {7'd0, bus.cmd_ready}, 8'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_rd     = rd;
    bus.cmd_rs1    = rs1;
    bus.cmd_rs2    = rs2;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.cmd_we     = we;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    if (legal) begin
      check({tag, "_exec_rsp_valid"}, {7'd0, bus.rsp_valid}, 8'd0);
      check({tag, "_exec_alu_a"}, {4'd0, bus.alu_a}, {4'd0, ea});
      check({tag, "_exec_alu_b"}, {4'd0, bus.alu_b}, {4'd0, eb});
      check({tag, "_exec_alu_op"}, {4'd0, bus.alu_op}, {4'd0, op});
      @(negedge clk);
    end else begin
      check({tag, "_alu_a_kept"}, {4'd0, bus.alu_a}, {4'd0, last_a});
      check({tag, "_alu_b_kept"}, {4'd0, bus.alu_b}, {4'd0, last_b});
      check({tag, "_alu_op_kept"}, {4'd0, bus.alu_op}, {4'd0, last_op});
    end
    check_rsp(tag, legal, exp);
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'h0;
      @(negedge clk);
      check_rsp({tag, "_hold"}, legal, exp);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_done_rsp_valid"}, {7'd0, bus.rsp_valid}, 8'd0);
    check({tag, "_done_cmd_ready"}, {7'd0, bus.cmd_ready}, 8'd1);
    if (legal) begin
      last_a  = ea;
      last_b  = eb;
      last_op = op;
      if (we) model_regs[rd] = exp[3:0];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 4'h0;
    bus.cmd_rd     = 2'd0;
    bus.cmd_rs1    = 2'd0;
    bus.cmd_rs2    = 2'd0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = 4'h0;
    bus.cmd_we     = 1'b0;
    bus.rsp_ready  = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    check("rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    check("rst_rsp_result", {4'd0, bus.rsp_result}, 8'd0);
    check("rst_flags", {5'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 8'd0);
    check("rst_alu", {bus.alu_a, bus.alu_b}, 8'd0);
    check("rst_alu_op", {4'd0, bus.alu_op}, 8'd0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready_before_edge", {7'd0, bus.cmd_ready}, 8'd0);
    @(negedge clk);
    check("rel_cmd_ready_after_edge", {7'd0, bus.cmd_ready}, 8'd1);

    run_cmd("load_r0", 4'hF, 2'd0, 2'd0, 2'd0, 1'b1, 4'd7, 1'b1, 0);
    run_cmd("read_r0", 4'hF, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 0);
    run_cmd("load_r1", 4'hF, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5, 1'b1, 0);
    run_cmd("add_imm", 4'h0, 2'd2, 2'd0, 2'd3, 1'b1, 4'd8, 1'b0, 0);
    run_cmd("sub_self", 4'h1, 2'd1, 2'd1, 2'd1, 1'b0, 4'd0, 1'b1, 0);
    run_cmd("read_r1", 4'hF, 2'd3, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 0);
    check("r1_cleared", {4'd0, bus.rsp_result}, 8'd0);
    run_cmd("illegal", 4'h8, 2'd0, 2'd1, 2'd1, 1'b0, 4'd0, 1'b1, 2);
    run_cmd("read_r0b", 4'hF, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 0);
    check("r0_kept", {4'd0, bus.rsp_result}, 8'd7);
    run_cmd("stall", 4'h5, 2'd2, 2'd0, 2'd0, 1'b1, 4'd3, 1'b1, 5);
    run_cmd("div0", 4'h6, 2'd3, 2'd0, 2'd1, 1'b0, 4'd0, 1'b1, 0);

    // Abort a write-back by resetting during EXEC.
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 4'h0;
    bus.cmd_rd     = 2'd3;
    bus.cmd_rs1    = 2'd0;
    bus.cmd_rs2    = 2'd2;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_we     = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n         = 1'b0;
    #1;
    check("abort_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    check("abort_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    check("abort_alu", {bus.alu_a, bus.alu_b}, 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rsp_valid_after", {7'd0, bus.rsp_valid}, 8'd0);
    run_cmd("read_r3", 4'hF, 2'd0, 2'd3, 2'd0, 1'b0, 4'd0, 1'b0, 0);
    check("r3_zero", {4'd0, bus.rsp_result}, 8'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 4'($urandom_range(0, 15));
      end else begin
        case ($urandom_range(0, 6))
          0: op = 4'h0;
          1: op = 4'h1;
          2: op = 4'h2;
          3: op = 4'h4;
          4: op = 4'h5;
          5: op = 4'h6;
          default: op = 4'hF;
        endcase
      end
      run_cmd("rand", op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)));
    end
    for (int r = 0; r < 4; r++) begin
      run_cmd("final_read", 4'hF, 2'd0, 2'(r), 2'd0, 1'b0, 4'd0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
